cdb_arbiter: RTL

- Consumer end of the per-FU result interface. It receives the cdb_t results produced by the add, mul, div and br functional units.
- Each FU gets its own small result queue. Every cycle, up to NUM_CDB queue heads are granted onto the broadcast buses. Those buses feed the ROB, the physical regfile and reservation-station wakeup.
- Absorbs same-cycle completion collisions between fixed-latency units (add/br comb, mul 4-cycle, div NUM_DIV_CYCLES). Gives the issue logic per-FU full flags.

---
 rtl/cdb_arbiter_pkg.sv | 23 ++
 rtl/cdb_fifo.sv | 60 ++++++
 rtl/cdb_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_pkg.sv
// rv32i_types: shared result-bus types and sizing for the CDB arbiter slice.
package rv32i_types;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rob_idx;
    logic [5:0]  pd;
    logic [4:0]  rd_s;
    logic [31:0] rd_v;
  } cdb_t;

  localparam int unsigned NUM_FU         = 4;
  localparam int unsigned NUM_CDB        = 2;
  localparam int unsigned CDB_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    FU_ADD,
    FU_MUL,
    FU_DIV,
    FU_BR
  } fu_idx_t;

endpackage

// File: rtl/cdb_fifo.sv
// cdb_fifo: one functional unit's result queue. Occupancy is tracked
// separately from the wrapping pointers so full and empty stay distinct.
module cdb_fifo
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH = CDB_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  cdb_t                       din,
  output cdb_t                       head,
  output logic                       full,
  output logic                       empty,
  output logic                       drop,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  cdb_t          mem [DEPTH];
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic          do_push;
  logic          do_pop;

  // Status flags; a push into a full queue survives only if the head leaves this cycle.
  always_comb begin
    full    = (count == CW'(DEPTH));
    empty   = (count == '0);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    drop    = push && full && !do_pop;
  end

  assign head = mem[head_ptr];

  // Pointer and occupancy update; flush and reset empty the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_push) tail_ptr <= tail_ptr + PW'(1);
      if (do_pop)  head_ptr <= head_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  // Entry storage, written at the tail on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) mem[tail_ptr] <= din;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: queues per-FU results and grants up to NUM_CDB queue heads
// per cycle onto the broadcast buses, round-robin from rr_ptr.
// Optional CDB_ARB_BR_PRIO_EN: a non-empty branch queue always owns bus 0.
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned NUM_FU     = rv32i_types::NUM_FU,
  parameter int unsigned NUM_CDB    = rv32i_types::NUM_CDB,
  parameter int unsigned FIFO_DEPTH = CDB_FIFO_DEPTH,
  parameter int unsigned BR_FU_IDX  = 32'(FU_BR)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  cdb_t [NUM_FU-1:0]                       fu_cdb,
  input  logic                                    global_branch_signal,
  output cdb_t [NUM_CDB-1:0]                      cdb_out,
  output logic [NUM_FU*NUM_CDB-1:0]               cdb_src,
  output logic [NUM_FU-1:0]                       fu_full,
  output logic [NUM_FU*$clog2(FIFO_DEPTH+1)-1:0]  fu_count,
  output logic                                    overflow_err
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned RW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

`ifdef CDB_ARB_BR_PRIO_EN
  localparam logic [NUM_FU-1:0] RR_MASK = ~(NUM_FU'(1) << BR_FU_IDX);
`else
  localparam logic [NUM_FU-1:0] RR_MASK = '1;
`endif

  cdb_t [NUM_FU-1:0]  heads;
  logic [NUM_FU-1:0]  empty;
  logic [NUM_FU-1:0]  drop;
  logic [NUM_FU-1:0]  push;
  logic [NUM_FU-1:0]  grant;
  logic [NUM_CDB-1:0] bus_vld;
  logic [RW-1:0]      sel [NUM_CDB];
  logic [RW-1:0]      rr_ptr;
  logic [RW-1:0]      rr_next;
  logic               rr_hit;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
    assign push[i] = fu_cdb[i].valid && !global_branch_signal;

    cdb_fifo #(
      .DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .flush(global_branch_signal),
      .push (push[i]),
      .pop  (grant[i]),
      .din  (fu_cdb[i]),
      .head (heads[i]),
      .full (fu_full[i]),
      .empty(empty[i]),
      .drop (drop[i]),
      .count(fu_count[i*CW +: CW])
    );
  end

  // Grant selection: optional branch priority on bus 0, then round-robin
  // fill. Buses are matched by comparison against the running grant count so
  // no data-dependent index is needed.
  always_comb begin
    int unsigned n;
    int unsigned f;
    grant   = '0;
    bus_vld = '0;
    rr_hit  = 1'b0;
    rr_next = rr_ptr;
    n       = 0;
    f       = 0;
    for (int unsigned k = 0; k < NUM_CDB; k++) sel[k] = '0;
`ifdef CDB_ARB_BR_PRIO_EN
    if (!empty[BR_FU_IDX]) begin
      grant[BR_FU_IDX] = 1'b1;
      sel[0]           = RW'(BR_FU_IDX);
      bus_vld[0]       = 1'b1;
      n                = 1;
    end
`endif
    for (int unsigned off = 0; off < NUM_FU; off++) begin
      f = (32'(rr_ptr) + off) % NUM_FU;
      for (int unsigned q = 0; q < NUM_FU; q++) begin
        if (q == f && RR_MASK[q] && !empty[q] && !grant[q] && n < NUM_CDB) begin
          grant[q] = 1'b1;
          for (int unsigned k = 0; k < NUM_CDB; k++) begin
            if (k == n) begin
              sel[k]     = RW'(q);
              bus_vld[k] = 1'b1;
            end
          end
          n       = n + 1;
          rr_next = RW'((q + 1) % NUM_FU);
          rr_hit  = 1'b1;
        end
      end
    end
  end

  // Bus drive from granted heads; flush and reset blank every bus.
  always_comb begin
    cdb_out = '0;
    cdb_src = '0;
    for (int unsigned k = 0; k < NUM_CDB; k++) begin
      if (bus_vld[k] && !global_branch_signal && !rst) begin
        cdb_out[k]                   = heads[sel[k]];
        cdb_src[k*NUM_FU +: NUM_FU]  = NUM_FU'(1) << sel[k];
      end
    end
  end

  // Round-robin pointer (held across flush) and sticky drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr       <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (rr_hit && !global_branch_signal) rr_ptr <= rr_next;
      if (|drop) overflow_err <= 1'b1;
    end
  end

endmodule
